// File: rtl/pipelined_barrel_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter_if
// Handshake bundle for the pipelined barrel shifter.
//   in_valid/in_ready   : upstream operation handshake
//   in_data/in_shamt    : operand and shift amount (0..WIDTH-1)
//   in_op               : 00 SRL, 01 SRA, 10 SLL, 11 ROR
//   in_tag              : opaque sideband tag, returned with the result
//   out_valid/out_ready : downstream result handshake
//   out_data/out_tag    : shifted result and its tag
//   out_zero/out_carry  : result flags, present only with SHIFTER_FLAGS_EN
// Modports: master = operand source / result sink, slave = the shifter.
// ---------------------------------------------------------------------------
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_FLAGS_EN
    logic             out_zero;
    logic             out_carry;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_zero, out_carry
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_zero, out_carry
    );
`else
    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
// Fully pipelined barrel shifter (SRL/SRA/SLL/ROR) with SHW = log2(WIDTH)
// registered stages, one operation per cycle, valid/ready backpressure,
// flush and a sideband tag.
//   clk   : clock, all state on the rising edge
//   rst   : synchronous active-high reset (drops every in-flight op)
//   flush : synchronous discard of all in-flight ops (rst has priority)
//   bus   : pipelined_barrel_shifter_if.slave (operand in, result out)
// Optional feature macro: SHIFTER_FLAGS_EN adds registered out_zero and
// out_carry (last bit shifted out) on the interface.
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;

    // One partial shift by s; anything not SRL/SRA/SLL is the rotate.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       op,
                                                  input int unsigned      s);
        logic signed [WIDTH-1:0] ds;
        ds = d;
        case (op)
            OP_SRL:  shift_by = d >> s;
            // Partial arithmetic shifts keep the original sign bit in the
            // MSB, so every later stage sees the operand's original sign.
            OP_SRA:  shift_by = ds >>> s;
            OP_SLL:  shift_by = d << s;
            default: shift_by = (d >> s) | (d << (WIDTH - s));
        endcase
    endfunction

`ifdef SHIFTER_FLAGS_EN
    // Last bit leaving the word for a partial shift by s. Partial shifts
    // compose, so the last applied stage yields the overall carry; for ROR
    // that bit lands in the MSB and stays there through later stages.
    function automatic logic carry_of(input logic [WIDTH-1:0] d,
                                      input logic [1:0]       op,
                                      input int unsigned      s);
        logic [WIDTH-1:0] t;
        if (op == OP_SLL) t = d >> (WIDTH - s);
        else              t = d >> (s - 1);
        carry_of = t[0];
    endfunction
`endif

    // Stage registers. The final stage needs no op/shamt, so those arrays
    // stop one short.
    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [TAG_W-1:0] tag_q   [SHW];
    logic [TAG_W-1:0] tag_d   [SHW];
    logic [1:0]       op_q    [SHW-1];
    logic [1:0]       op_d    [SHW-1];
    logic [SHW-1:0]   shamt_q [SHW-1];
    logic [SHW-1:0]   shamt_d [SHW-1];
    logic [SHW-1:0]   vld_q;
    logic [SHW-1:0]   vld_d;

    // Inputs feeding each stage: stage 0 from the bus, stage k from k-1.
    logic [WIDTH-1:0] src_data  [SHW];
    logic [TAG_W-1:0] src_tag   [SHW];
    logic [1:0]       src_op    [SHW];
    logic [SHW-1:0]   src_shamt [SHW];
    logic [SHW-1:0]   src_vld;
    logic             adv;

    assign adv          = ~vld_q[SHW-1] | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        src_data  = '{default: '0};
        src_tag   = '{default: '0};
        src_op    = '{default: '0};
        src_shamt = '{default: '0};
        src_data[0]  = bus.in_data;
        src_tag[0]   = bus.in_tag;
        src_op[0]    = bus.in_op;
        src_shamt[0] = bus.in_shamt;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_tag[k]   = tag_q[k-1];
            src_op[k]    = op_q[k-1];
            src_shamt[k] = shamt_q[k-1];
        end
        // An input offered during flush is dropped although in_ready is 1.
        src_vld = {vld_q[SHW-2:0], bus.in_valid & adv & ~flush};
    end

    // The shamt travels left-shifted by one per stage, so stage k always
    // tests the MSB, which holds original bit SHW-1-k (weight 2^(SHW-1-k)).
    always_comb begin
        data_d  = data_q;
        tag_d   = tag_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        vld_d   = vld_q;
        if (adv) begin
            vld_d = src_vld;
            for (int k = 0; k < SHW; k++) begin
                data_d[k] = src_shamt[k][SHW-1]
                          ? shift_by(src_data[k], src_op[k], 1 << (SHW - 1 - k))
                          : src_data[k];
                tag_d[k]  = src_tag[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_d[k]    = src_op[k];
                shamt_d[k] = src_shamt[k] << 1;
            end
        end
        if (flush) vld_d = '0;
    end

    // ---- stage registers (stage 0 .. SHW-1) ----
    always_ff @(posedge clk) begin
        data_q  <= data_d;
        tag_q   <= tag_d;
        op_q    <= op_d;
        shamt_q <= shamt_d;
        if (rst) begin
            vld_q          <= '0;
            data_q[SHW-1]  <= '0;
            tag_q[SHW-1]   <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign bus.out_valid = vld_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
    assign bus.out_tag   = tag_q[SHW-1];

`ifdef SHIFTER_FLAGS_EN
    logic src_carry [SHW];
    logic carry_q   [SHW];
    logic carry_d   [SHW];
    logic zero_q;
    logic zero_d;

    always_comb begin
        src_carry    = '{default: 1'b0};
        src_carry[0] = 1'b0;
        for (int k = 1; k < SHW; k++) src_carry[k] = carry_q[k-1];
    end

    always_comb begin
        carry_d = carry_q;
        if (adv) begin
            for (int k = 0; k < SHW; k++) begin
                carry_d[k] = src_shamt[k][SHW-1]
                           ? carry_of(src_data[k], src_op[k], 1 << (SHW - 1 - k))
                           : src_carry[k];
            end
        end
        // Follows data_d, so it holds with the data under stall.
        zero_d = (data_d[SHW-1] == '0);
    end

    // ---- flag registers, aligned with the final stage ----
    always_ff @(posedge clk) begin
        carry_q <= carry_d;
        zero_q  <= zero_d;
        if (rst) begin
            carry_q[SHW-1] <= 1'b0;
            zero_q         <= 1'b0;
        end
    end

    assign bus.out_carry = carry_q[SHW-1];
    assign bus.out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
// Directed bench for pipelined_barrel_shifter (WIDTH=32, SHW=5) with a
// scoreboard queue: expectations are pushed on acceptance and compared when
// a result is taken. Define SHIFTER_FLAGS_EN to also check the flags.
// ---------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        carry;
        logic        zero;
        int          acc_cyc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          lat_on, bp_on, rnd_rdy, ready_one, stall_prev;
    int          bp_base;
    logic [31:0] held_data;
    logic [3:0]  held_tag;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference shifter written straight from the mode definitions.
    function automatic exp_t model(input logic [31:0] d, input logic [4:0] sh,
                                   input logic [1:0] op, input logic [3:0] tag);
        exp_t        e;
        logic [63:0] w;
        logic [31:0] t;
        int          n;
        n = int'(sh);
        case (op)
            2'b00: e.data = d >> n;
            2'b01: begin
                e.data = d >> n;
                if (d[31]) e.data = e.data | ~(32'hFFFF_FFFF >> n);
            end
            2'b10: e.data = d << n;
            default: begin
                w      = {d, d} >> n;
                e.data = w[31:0];
            end
        endcase
        if (n == 0)            e.carry = 1'b0;
        else if (op == 2'b11)  e.carry = e.data[31];
        else if (op == 2'b10) begin t = d >> (32 - n); e.carry = t[0]; end
        else                  begin t = d >> (n - 1);  e.carry = t[0]; end
        e.zero    = (e.data == 32'h0);
        e.tag     = tag;
        e.acc_cyc = cyc;
        e.lat     = lat_on;
        return e;
    endfunction

    // One clock: observe at the falling edge, commit at the rising edge.
    task automatic step(output bit acc);
        exp_t e;
        if (bp_on)   bus.out_ready = !((cyc - bp_base) inside {[7:9]});
        if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        acc = bus.in_valid && bus.in_ready && !flush && !rst;
        chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
        if (ready_one) chk("in_ready_stream", bus.in_ready, 1'b1);
        if (stall_prev) begin
            chk("hold_valid", bus.out_valid, 1'b1);
            chk("hold_data", bus.out_data, held_data);
            chk("hold_tag", bus.out_tag, held_tag);
        end
        stall_prev = bus.out_valid && !bus.out_ready && !rst && !flush;
        held_data  = bus.out_data;
        held_tag   = bus.out_tag;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", bus.out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_tag", bus.out_tag, e.tag);
`ifdef SHIFTER_FLAGS_EN
                chk("out_carry", bus.out_carry, e.carry);
                chk("out_zero", bus.out_zero, e.zero);
`endif
                if (e.lat) chk("latency", cyc - e.acc_cyc, SHW);
            end
        end
        if (rst || flush) sb.delete();
        if (acc) sb.push_back(model(bus.in_data, bus.in_shamt, bus.in_op, bus.in_tag));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] sh,
                        input logic [1:0] op, input logic [3:0] tag);
        bit a;
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = sh;
        bus.in_op    = op;
        bus.in_tag   = tag;
        do begin
            step(a);
            n++;
        end while (!a && n < 50);
        if (!a) chk("send_timeout", a, 1'b1);
    endtask

    task automatic idle(input int n);
        bit a;
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.in_data  = $urandom;
            bus.in_shamt = 5'($urandom);
            bus.in_op    = 2'($urandom);
            step(a);
        end
    endtask

    task automatic drain(input int max_cyc);
        bit a;
        int n;
        n = 0;
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < max_cyc) begin
            step(a);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        bit a;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        flush = 1'b0;
        lat_on = 0; bp_on = 0; rnd_rdy = 0; ready_one = 0; stall_prev = 0;
        bp_base = 0;

        step(a);
        step(a);
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_tag", bus.out_tag, 4'h0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
`ifdef SHIFTER_FLAGS_EN
        chk("rst_out_zero", bus.out_zero, 1'b0);
        chk("rst_out_carry", bus.out_carry, 1'b0);
`endif

        // Mode checks, each isolated so latency is exactly SHW.
        lat_on = 1;
        send(32'h8000_0000, 5'd4,  2'b01, 4'h1); drain(20);
        send(32'h8000_0000, 5'd31, 2'b00, 4'h2); drain(20);
        send(32'h0000_0001, 5'd31, 2'b10, 4'h3); drain(20);
        send(32'h0000_0001, 5'd1,  2'b11, 4'h4); drain(20);
        send(32'h1234_5678, 5'd8,  2'b11, 4'h5); drain(20);
        send(32'h7000_0000, 5'd3,  2'b01, 4'h6); drain(20);
        for (int op = 0; op < 4; op++) begin
            send(32'hA5C3_0F96, 5'd0, 2'(op), 4'(8 + op));
        end
        drain(20);

        // Streaming: 16 back-to-back ops, in_ready must never drop.
        ready_one = 1;
        for (int i = 0; i < 16; i++) send($urandom, 5'($urandom), 2'($urandom), 4'(i));
        drain(20);
        ready_one = 0;

        // Backpressure: out_ready low for stream-relative cycles 7..9.
        lat_on  = 0;
        bp_on   = 1;
        bp_base = cyc;
        for (int i = 0; i < 16; i++) send($urandom, 5'($urandom), 2'($urandom), 4'(i));
        drain(40);
        bp_on = 0;
        bus.out_ready = 1'b1;

        // Flush with 3 ops in flight; the op offered with flush is dropped.
        for (int i = 0; i < 3; i++) send($urandom, 5'($urandom), 2'($urandom), 4'(i));
        bus.in_valid = 1'b1;
        bus.in_tag   = 4'hA;
        flush = 1'b1;
        chk("flush_in_ready", bus.in_ready, 1'b1);
        step(a);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("flush_out_valid", bus.out_valid, 1'b0);
        end
        lat_on = 1;
        send(32'hDEAD_BEEF, 5'd12, 2'b00, 4'hB);
        drain(20);

        // Reset with 4 ops in flight.
        lat_on = 0;
        for (int i = 0; i < 4; i++) send($urandom, 5'($urandom), 2'($urandom), 4'(i + 4));
        rst = 1'b1;
        step(a);
        rst = 1'b0;
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_out_data", bus.out_data, 32'h0);
        chk("midrst_out_tag", bus.out_tag, 4'h0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk("midrst_no_stale", bus.out_valid, 1'b0);
        end

        // Random ops under random backpressure.
        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) send($urandom, 5'($urandom), 2'($urandom), 4'($urandom));
        drain(200);
        rnd_rdy = 0;
        bus.out_ready = 1'b1;

`ifdef SHIFTER_FLAGS_EN
        lat_on = 1;
        send(32'h0000_0003, 5'd1, 2'b00, 4'h1);
        send(32'h8000_0000, 5'd1, 2'b10, 4'h2);
        send(32'hFFFF_FFFF, 5'd0, 2'b01, 4'h3);
        send(32'h0000_0000, 5'd0, 2'b11, 4'h4);
        drain(20);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
